// File: rtl/systolic_tile_controller.sv
// rtl/systolic_tile_controller.sv - control sequencer for one weight-stationary systolic tile job
//
// Sequences one matrix-tile job: load N input rows into the skew buffer,
// stream them through the array, drain the reverse-skew buffer, then hand
// N result rows downstream. Holds only the FSM and its counters.
//
// Optional feature macro: STC_PERF_CNT_EN adds perf_cycles/stall_cycles.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           job request, honoured only while idle
//   busy, done      job in progress / one-cycle completion pulse
//   a_valid/a_ready input row stream handshake
//   skew_write, skew_row_ptr, skew_enable   input skew buffer control
//   array_clear     PE accumulator clear (held through the load phase)
//   rsb_enable, rsb_write, rsb_read         reverse-skew buffer control
//   out_valid/out_ready                     result row stream handshake
//   perf_cycles, stall_cycles               (STC_PERF_CNT_EN only) job statistics
module systolic_tile_controller #(
  parameter int ARRAY_SIZE     = 8,
  parameter int COMPUTE_CYCLES = 3 * ARRAY_SIZE - 2,
  parameter int DRAIN_CYCLES   = 2 * ARRAY_SIZE - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          a_valid,
  output logic                          a_ready,
  output logic                          skew_write,
  output logic [$clog2(ARRAY_SIZE)-1:0] skew_row_ptr,
  output logic                          skew_enable,
  output logic                          array_clear,
  output logic                          rsb_enable,
  output logic                          rsb_write,
  output logic                          rsb_read,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef STC_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_cycles,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int CW        = $clog2(ARRAY_SIZE);
  localparam int PHASE_MAX = (COMPUTE_CYCLES > DRAIN_CYCLES) ? COMPUTE_CYCLES : DRAIN_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);

  localparam logic [CW-1:0] LAST_ROW     = CW'(ARRAY_SIZE - 1);
  localparam logic [PW-1:0] LAST_COMPUTE = PW'(COMPUTE_CYCLES - 1);
  localparam logic [PW-1:0] LAST_DRAIN   = PW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] load_cnt, load_cnt_next;
  logic [CW-1:0] out_cnt, out_cnt_next;
  logic [PW-1:0] phase_cnt, phase_cnt_next;
  logic          done_q, done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      out_cnt   <= '0;
      phase_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      load_cnt  <= load_cnt_next;
      out_cnt   <= out_cnt_next;
      phase_cnt <= phase_cnt_next;
      done_q    <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_cnt_next  = load_cnt;
    out_cnt_next   = out_cnt;
    phase_cnt_next = phase_cnt;
    done_next      = 1'b0;
    a_ready        = 1'b0;
    skew_row_ptr   = '0;
    skew_enable    = 1'b0;
    array_clear    = 1'b0;
    rsb_enable     = 1'b0;
    rsb_write      = 1'b0;
    rsb_read       = 1'b0;
    out_valid      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next     = S_LOAD;
          load_cnt_next  = '0;
          out_cnt_next   = '0;
          phase_cnt_next = '0;
        end
      end
      S_LOAD: begin
        a_ready      = 1'b1;
        array_clear  = 1'b1;
        skew_row_ptr = load_cnt;
        if (a_valid) begin
          if (load_cnt == LAST_ROW) begin
            state_next     = S_STREAM;
            load_cnt_next  = '0;
            phase_cnt_next = '0;
          end else begin
            load_cnt_next = load_cnt + 1'b1;
          end
        end
      end
      S_STREAM: begin
        skew_enable = 1'b1;
        if (phase_cnt == LAST_COMPUTE) begin
          state_next     = S_DRAIN;
          phase_cnt_next = '0;
        end else begin
          phase_cnt_next = phase_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        rsb_enable = 1'b1;
        rsb_write  = 1'b1;
        if (phase_cnt == LAST_DRAIN) begin
          state_next     = S_OUTPUT;
          phase_cnt_next = '0;
          out_cnt_next   = '0;
        end else begin
          phase_cnt_next = phase_cnt + 1'b1;
        end
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        rsb_read  = out_ready;
        if (out_ready) begin
          if (out_cnt == LAST_ROW) begin
            state_next   = S_IDLE;
            out_cnt_next = '0;
            done_next    = 1'b1;
          end else begin
            out_cnt_next = out_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Outputs are forced low while rst is asserted so an aborted job cannot
    // leave a buffer strobe active during the reset cycle itself.
    if (rst) begin
      a_ready      = 1'b0;
      skew_row_ptr = '0;
      skew_enable  = 1'b0;
      array_clear  = 1'b0;
      rsb_enable   = 1'b0;
      rsb_write    = 1'b0;
      rsb_read     = 1'b0;
      out_valid    = 1'b0;
    end
  end

  assign skew_write = a_valid & a_ready;
  assign busy       = (state != S_IDLE) & ~rst;
  assign done       = done_q & ~rst;

`ifdef STC_PERF_CNT_EN
  logic [31:0] perf_q;
  logic [31:0] stall_q;
  logic        stall_now;

  assign stall_now = ((state == S_LOAD) & ~a_valid) | ((state == S_OUTPUT) & ~out_ready);

  // perf_q is loaded with 1 on the accepting edge so that the value seen in
  // the done cycle already includes that cycle; it stops counting in IDLE,
  // which latches the result until the next job starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q  <= '0;
      stall_q <= '0;
    end else if ((state == S_IDLE) && start) begin
      perf_q  <= 32'd1;
      stall_q <= '0;
    end else begin
      if ((state != S_IDLE) && (perf_q != '1)) begin
        perf_q <= perf_q + 32'd1;
      end
      if (stall_now && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_cycles  = rst ? '0 : perf_q;
  assign stall_cycles = rst ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_systolic_tile_controller.sv
// tb/tb_systolic_tile_controller.sv - self-checking bench for systolic_tile_controller
module tb_systolic_tile_controller;

  localparam int N = 4;
  localparam int C = 3 * N - 2;
  localparam int D = 2 * N - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       a_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, done, a_ready, skew_write;
  logic [1:0] skew_row_ptr;
  logic       skew_enable, array_clear, rsb_enable, rsb_write, rsb_read, out_valid;
`ifdef STC_PERF_CNT_EN
  logic [31:0] perf_cycles, stall_cycles;
`endif

  always #5 clk = ~clk;

  systolic_tile_controller #(.ARRAY_SIZE(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .skew_write  (skew_write),
    .skew_row_ptr(skew_row_ptr),
    .skew_enable (skew_enable),
    .array_clear (array_clear),
    .rsb_enable  (rsb_enable),
    .rsb_write   (rsb_write),
    .rsb_read    (rsb_read),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef STC_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles),
    .stall_cycles(stall_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Job model: progress is tracked as rows loaded, cycles elapsed since the
  // last row arrived, and rows returned; the phase follows from those counts.
  int m_busy = 0, m_loaded = 0, m_post = 0, m_outs = 0;
  int m_done = 0, m_jc = 0, m_stall = 0;

  function automatic int m_phase();
    if (m_busy == 0) return 0;
    if (m_loaded < N) return 1;
    if (m_post < C) return 2;
    if (m_post < C + D) return 3;
    return 4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_loaded <= 0; m_post <= 0; m_outs <= 0;
      m_done <= 0; m_jc <= 0; m_stall <= 0;
    end else begin
      m_done <= 0;
      if (m_phase() != 0) m_jc <= m_jc + 1;
      case (m_phase())
        0: if (start) begin
          m_busy <= 1; m_loaded <= 0; m_post <= 0; m_outs <= 0;
          m_jc <= 0; m_stall <= 0;
        end
        1: if (a_valid) m_loaded <= m_loaded + 1; else m_stall <= m_stall + 1;
        2, 3: m_post <= m_post + 1;
        4: if (out_ready) begin
          m_outs <= m_outs + 1;
          if (m_outs + 1 == N) begin
            m_busy <= 0;
            m_done <= 1;
          end
        end else begin
          m_stall <= m_stall + 1;
        end
        default: ;
      endcase
    end
  end

  int n_sw = 0, n_se = 0, n_rw = 0, n_rr = 0, n_done = 0, n_ac = 0;
  int ptrs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] out_vec();
    return {busy, done, a_ready, skew_write, skew_row_ptr, skew_enable,
            array_clear, rsb_enable, rsb_write, rsb_read, out_valid};
  endfunction

  task automatic compare_now();
    logic [11:0] exp;
    int ph;
    #1;
    ph = m_phase();
    if (rst) exp = '0;
    else exp = {m_busy != 0, m_done != 0, ph == 1, (ph == 1) && a_valid,
                (ph == 1) ? 2'(m_loaded) : 2'b00, ph == 2, ph == 1,
                ph == 3, ph == 3, (ph == 4) && out_ready, ph == 4};
    check("outputs", out_vec(), exp);
`ifdef STC_PERF_CNT_EN
    if (!rst && m_done != 0) begin
      check("perf_cycles", perf_cycles, m_jc + 1);
      check("stall_cycles", stall_cycles, m_stall);
    end
`endif
    if (!rst) begin
      if (skew_write) begin n_sw++; ptrs.push_back(int'(skew_row_ptr)); end
      if (skew_enable) n_se++;
      if (rsb_write) n_rw++;
      if (rsb_read) n_rr++;
      if (done) n_done++;
      if (array_clear) n_ac++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_now();
    end
  endtask

  // Caller is positioned in a cycle before the rising edge; start is raised
  // here and sampled on the next edge. Returns in the done cycle.
  task automatic run_job(input logic [15:0] lpat, input logic [15:0] opat,
                         input int start_at, input int rst_at,
                         input int exp_lat, input int exp_ac, input string tag);
    int lat, li, oi, p0;
    int b_sw, b_se, b_rw, b_rr, b_done, b_ac;
    bit fin;
    b_sw = n_sw; b_se = n_se; b_rw = n_rw; b_rr = n_rr; b_done = n_done; b_ac = n_ac;
    p0 = ptrs.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    lat = 1; li = 0; oi = 0; fin = 0;
    while (!fin) begin
      if (rst_at != 0 && lat == rst_at) rst = 1'b1;
      if (rst_at != 0 && lat == rst_at + 1) rst = 1'b0;
      start = (lat == start_at);
      a_valid = a_ready ? lpat[li] : 1'b0;
      if (a_ready) li++;
      out_ready = out_valid ? opat[oi] : 1'b0;
      if (out_valid) oi++;
      compare_now();
      if (rst_at != 0 && lat == rst_at + 1) begin
        check({tag, "_after_abort"}, out_vec(), 12'h000);
        fin = 1;
      end else if (done) begin
        fin = 1;
      end else if (lat >= 300) begin
        check({tag, "_timeout"}, 1, 0);
        fin = 1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    a_valid = 1'b0;
    out_ready = 1'b0;
    if (rst_at == 0) begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_skew_writes"}, n_sw - b_sw, 4);
      for (int i = 0; i < 4; i++)
        check({tag, "_row_ptr"}, (ptrs.size() > p0 + i) ? ptrs[p0 + i] : -1, i);
      check({tag, "_skew_enable"}, n_se - b_se, 10);
      check({tag, "_rsb_write"}, n_rw - b_rw, 7);
      check({tag, "_rsb_read"}, n_rr - b_rr, 4);
      check({tag, "_done_count"}, n_done - b_done, 1);
      check({tag, "_array_clear"}, n_ac - b_ac, exp_ac);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      compare_now();
      check("reset_outputs", out_vec(), 12'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    compare_now();
    check("idle_after_reset", out_vec(), 12'h000);
    idle(2);

    run_job(16'hFFFF, 16'hFFFF, 0, 0, 26, 4, "t1");
    idle(3);
    run_job(16'h5555, 16'hFFFF, 0, 0, 29, 7, "t2");
    idle(3);
    run_job(16'hFFFF, 16'h8888, 0, 0, 38, 4, "t3");
    idle(3);
    run_job(16'hFFFF, 16'hFFFF, 8, 0, 26, 4, "t4a");
    run_job(16'hFFFF, 16'hFFFF, 0, 0, 26, 4, "t4b");
    idle(3);
    run_job(16'hFFFF, 16'hFFFF, 0, 17, 0, 0, "t5");
    idle(2);
    run_job(16'hFFFF, 16'hFFFF, 0, 0, 26, 4, "t5b");
    idle(3);
    run_job(16'hFFF5, 16'hFFEA, 0, 0, 31, 6, "t6");
`ifdef STC_PERF_CNT_EN
    check("t6_perf_literal", perf_cycles, 31);
    check("t6_stall_literal", stall_cycles, 5);
`endif
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/systolic_tile_controller.md
Name: systolic_tile_controller

Overview:
Top-level sequencer for one matrix-tile job on the weight-stationary systolic array. It takes a start command and N input rows over a valid/ready stream, then drives the input skew buffer (write, row pointer, enable), the array accumulator clear, and the output reverse-skew buffer (enable, write, read). It returns N result rows over a valid/ready stream. It holds no datapath storage: only control signals, counters and the FSM.

Parameters:
ARRAY_SIZE, 8, N: array dimension, the number of rows loaded and the number of rows returned
COMPUTE_CYCLES, 3*ARRAY_SIZE-2, cycles skew_enable stays high in STREAM (the skew plus the array pipeline depth)
DRAIN_CYCLES, 2*ARRAY_SIZE-1, cycles rsb_enable/rsb_write stay high in DRAIN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job request pulse; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on the return to IDLE after the last output beat
a_valid  in  1  upstream row valid
a_ready  out  1  high in LOAD
skew_write  out  1  equals a_valid & a_ready
skew_row_ptr  out  $clog2(ARRAY_SIZE)  current load row index
skew_enable  out  1  skew buffer shift/read enable
array_clear  out  1  clears the PE accumulators
rsb_enable  out  1  reverse-skew enable
rsb_write  out  1  reverse-skew write
rsb_read  out  1  reverse-skew read-pointer advance
out_valid  out  1  result row valid (OUTPUT state)
out_ready  in  1  downstream accept

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. rst is synchronous and active-high.
- Reset and initial values:
  - rst forces IDLE and clears all counters.
  - All outputs are 0 during and after reset.
  - rst mid-job aborts immediately. Buffers are not touched; the next job re-initialises them.
- FSM states: IDLE, LOAD, STREAM, DRAIN, OUTPUT. Encoding is free.
- IDLE:
  - start=1 moves to LOAD on the next cycle and clears load_cnt.
  - start in any other state is ignored and is not queued.
- LOAD:
  - a_ready=1 and array_clear=1 for the whole state.
  - skew_row_ptr = load_cnt.
  - Each cycle with a_valid=1 is one beat and increments load_cnt.
  - The beat with load_cnt==N-1 moves to STREAM.
  - Gaps in a_valid are allowed; the FSM waits indefinitely.
- STREAM:
  - skew_enable=1 for exactly COMPUTE_CYCLES cycles, counted by phase_cnt.
  - Then move to DRAIN.
- DRAIN:
  - rsb_enable=1 and rsb_write=1 for exactly DRAIN_CYCLES cycles.
  - Then move to OUTPUT with out_cnt=0.
- OUTPUT:
  - out_valid=1.
  - rsb_read = out_valid & out_ready, one pulse per accepted row.
  - out_cnt increments per accepted row.
  - The accept with out_cnt==N-1 moves to IDLE; done=1 in that first IDLE cycle.
  - out_valid holds while out_ready=0 (backpressure). Data stability is the buffer's responsibility.
- Counters:
  - load_cnt and out_cnt are $clog2(ARRAY_SIZE) bits.
  - phase_cnt is wide enough for max(COMPUTE_CYCLES, DRAIN_CYCLES).
  - No wrap beyond N-1. Counters reset to 0 on every state entry.
- Minimum job latency, start accepted to done, with no stalls: 1 + N + COMPUTE_CYCLES + DRAIN_CYCLES + N cycles.
- start in the same cycle as done (IDLE) is accepted.
- Weight preload is out of scope.

Optional Feature:
Macro STC_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles, 32 bits, and output stall_cycles, 32 bits.
  - perf_cycles counts cycles from leaving IDLE to done, inclusive of the done cycle, and latches at done.
  - stall_cycles counts LOAD cycles with a_valid=0 plus OUTPUT cycles with out_ready=0.
  - Both are cleared on job start and on rst, and saturate at 2^32-1.
- Undefined: neither port nor its logic exists.

Test Plan:
- N=4, defaults, start pulse with a_valid=1 and out_ready=1 throughout -> 4 skew_write beats with row_ptr 0,1,2,3; skew_enable high 10 cycles; rsb_write high 7 cycles; 4 rsb_read pulses; done exactly 26 cycles after the start edge.
- LOAD with a_valid toggling 1,0,1,0,... -> only beats with a_valid=1 advance row_ptr; STREAM entered after the 4th valid beat; array_clear high throughout LOAD.
- OUTPUT with out_ready low 3 cycles before each accept -> out_valid stays 1; exactly 4 rsb_read pulses, each coincident with out_ready; done after the 4th.
- start asserted in STREAM, then again in the done cycle -> first ignored (job count 1); second accepted, with busy=1 on the next cycle.
- rst asserted mid-DRAIN -> next cycle all outputs 0 and busy=0; new start after reset runs a full 26-cycle job.
- STC_PERF_CNT_EN defined, Test 1 stimulus with 2 LOAD gaps and 3 OUTPUT stalls -> perf_cycles=31 and stall_cycles=5 at done.
